// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared constants, state encoding and address helpers for the LBP host model
package lbp_pkg;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 8;
  localparam int IMG_W    = 128;
  localparam int IMG_SIZE = IMG_W * IMG_W;
  localparam int COL_W    = $clog2(IMG_W);

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DUMP,
    DONE
  } state_e;

  // Border pixels have no full 3x3 neighbourhood, so the engine must never write them.
  function automatic logic is_border(input logic [ADDR_W-1:0] addr);
    logic [COL_W-1:0] row;
    logic [COL_W-1:0] col;
    row = addr[ADDR_W-1:COL_W];
    col = addr[COL_W-1:0];
    return (row == '0) || (row == COL_W'(IMG_W - 1)) ||
           (col == '0) || (col == COL_W'(IMG_W - 1));
  endfunction

endpackage

// File: rtl/lbp_result_store.sv
// rtl/lbp_result_store.sv - LBP result array with written bitmap, write filtering and unique-write count
module lbp_result_store
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              wr_err
);

  logic [DATA_W-1:0] res_mem [IMG_SIZE];

  logic [IMG_SIZE-1:0] written_q, written_d;
  logic                last_valid_q, last_valid_d;
  logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
  logic [DATA_W-1:0]   last_data_q, last_data_d;
  logic [ADDR_W:0]     wr_count_q, wr_count_d;
  logic                store_en;

  // Classify each write: border error, repeat of a held strobe, duplicate error, or a new store.
  // An absorbed repeat keeps the match window open so a strobe held for many cycles stays silent.
  always_comb begin
    written_d    = written_q;
    last_valid_d = 1'b0;
    last_addr_d  = last_addr_q;
    last_data_d  = last_data_q;
    wr_count_d   = wr_count_q;
    store_en     = 1'b0;
    wr_err       = 1'b0;
    if (wr_en) begin
      if (is_border(wr_addr)) begin
        wr_err = 1'b1;
      end else if (last_valid_q && (wr_addr == last_addr_q) && (wr_data == last_data_q)) begin
        last_valid_d = 1'b1;
      end else if (written_q[wr_addr]) begin
        wr_err = 1'b1;
      end else begin
        store_en           = 1'b1;
        written_d[wr_addr] = 1'b1;
        last_valid_d       = 1'b1;
        last_addr_d        = wr_addr;
        last_data_d        = wr_data;
        if (wr_count_q != (ADDR_W+1)'(IMG_SIZE)) begin
          wr_count_d = wr_count_q + 1'b1;
        end
      end
    end
  end

  // Bookkeeping registers; the bitmap is cleared by reset so stale results read back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      written_q    <= '0;
      last_valid_q <= 1'b0;
      last_addr_q  <= '0;
      last_data_q  <= '0;
      wr_count_q   <= '0;
    end else begin
      written_q    <= written_d;
      last_valid_q <= last_valid_d;
      last_addr_q  <= last_addr_d;
      last_data_q  <= last_data_d;
      wr_count_q   <= wr_count_d;
    end
  end

  // Result storage; contents are only meaningful where the bitmap is set.
  always_ff @(posedge clk) begin
    if (store_en) begin
      res_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data  = written_q[rd_addr] ? res_mem[rd_addr] : '0;
  assign wr_count = wr_count_q;

endmodule

// File: rtl/lbp_host_model.sv
// rtl/lbp_host_model.sv - host side of the LBP engine: image load, gray reads, result capture and dump
module lbp_host_model
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              dout_valid,
  output logic [ADDR_W-1:0] dout_addr,
  output logic [DATA_W-1:0] dout_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              err,
  output logic              done
);

  logic [DATA_W-1:0] pix_mem [IMG_SIZE];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] dump_cnt_q, dump_cnt_d;
  logic              gray_ready_q, gray_ready_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              dout_valid_q, dout_valid_d;
  logic [ADDR_W-1:0] dout_addr_q, dout_addr_d;
  logic [DATA_W-1:0] dout_data_q, dout_data_d;
  logic              pix_we;
  logic              store_wr_en;
  logic              store_wr_err;
  logic [DATA_W-1:0] store_rd_data;

  assign store_wr_en = lbp_valid && (state_q == SERVE);

  lbp_result_store u_store (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (store_wr_en),
    .wr_addr  (lbp_addr),
    .wr_data  (lbp_data),
    .rd_addr  (dump_cnt_q),
    .rd_data  (store_rd_data),
    .wr_count (wr_count),
    .wr_err   (store_wr_err)
  );

  // Next-state and output logic: protocol checks feed the sticky error, then per-state actions.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    dump_cnt_d   = dump_cnt_q;
    gray_ready_d = gray_ready_q;
    err_d        = err_q;
    done_d       = done_q;
    dout_valid_d = 1'b0;
    dout_addr_d  = dout_addr_q;
    dout_data_d  = dout_data_q;
    pix_we       = 1'b0;

    if (gray_req && (state_q != SERVE)) err_d = 1'b1;
    if (lbp_valid && (state_q != SERVE)) err_d = 1'b1;
    if (store_wr_err) err_d = 1'b1;

    case (state_q)
      LOAD: begin
        if (load_valid) begin
          pix_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (ptr_q == ADDR_W'(IMG_SIZE - 1)) begin
            state_d      = SERVE;
            gray_ready_d = 1'b1;
          end
        end
        if (finish) err_d = 1'b1;
      end
      SERVE: begin
        if (finish) begin
          state_d    = DUMP;
          dump_cnt_d = '0;
        end
      end
      DUMP: begin
        dout_valid_d = 1'b1;
        dout_addr_d  = dump_cnt_q;
        dout_data_d  = store_rd_data;
        dump_cnt_d   = dump_cnt_q + 1'b1;
        if (dump_cnt_q == ADDR_W'(IMG_SIZE - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Control and output registers; reset from any state restarts the image load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      ptr_q        <= '0;
      dump_cnt_q   <= '0;
      gray_ready_q <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_addr_q  <= '0;
      dout_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      dump_cnt_q   <= dump_cnt_d;
      gray_ready_q <= gray_ready_d;
      err_q        <= err_d;
      done_q       <= done_d;
      dout_valid_q <= dout_valid_d;
      dout_addr_q  <= dout_addr_d;
      dout_data_q  <= dout_data_d;
    end
  end

  // Pixel storage, filled in raster order during LOAD.
  always_ff @(posedge clk) begin
    if (pix_we) begin
      pix_mem[ptr_q] <= load_data;
    end
  end

  assign gray_data  = (gray_req && (state_q == SERVE)) ? pix_mem[gray_addr] : '0;
  assign gray_ready = gray_ready_q;
  assign err        = err_q;
  assign done       = done_q;
  assign dout_valid = dout_valid_q;
  assign dout_addr  = dout_addr_q;
  assign dout_data  = dout_data_q;

endmodule

// File: tb/tb_lbp_host_model.sv
// tb/tb_lbp_host_model.sv - scoreboard bench for lbp_host_model
`timescale 1ns/1ps
module tb_lbp_host_model;
  import lbp_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              gray_ready;
  logic              gray_req = 1'b0;
  logic [ADDR_W-1:0] gray_addr = '0;
  logic [DATA_W-1:0] gray_data;
  logic              lbp_valid = 1'b0;
  logic [ADDR_W-1:0] lbp_addr = '0;
  logic [DATA_W-1:0] lbp_data = '0;
  logic              finish = 1'b0;
  logic              dout_valid;
  logic [ADDR_W-1:0] dout_addr;
  logic [DATA_W-1:0] dout_data;
  logic [ADDR_W:0]   wr_count;
  logic              err;
  logic              done;

  int checks = 0;
  int errors = 0;
  int seen = 0;
  logic [21:0] exp_q[$];
  logic [21:0] mon_e;
  logic [DATA_W-1:0] exp_res [IMG_SIZE];

  lbp_host_model dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .dout_valid (dout_valid),
    .dout_addr  (dout_addr),
    .dout_data  (dout_data),
    .wr_count   (wr_count),
    .err        (err),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image();
    for (int i = 0; i < IMG_SIZE; i++) begin
      load_valid = 1'b1;
      load_data  = i[7:0];
      if (i == IMG_SIZE - 1) chk("gray_ready_before_last_load", 32'(gray_ready), 32'd0);
      tick();
    end
    load_valid = 1'b0;
    chk("gray_ready_after_last_load", 32'(gray_ready), 32'd1);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    lbp_valid = 1'b1;
    lbp_addr  = a;
    lbp_data  = d;
    tick();
    lbp_valid = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    gray_req  = 1'b1;
    gray_addr = a;
    #1;
    chk("gray_data", 32'(gray_data), 32'(exp));
  endtask

  task automatic clear_model();
    for (int a = 0; a < IMG_SIZE; a++) begin
      logic [31:0] av;
      av = a;
      exp_res[av[ADDR_W-1:0]] = '0;
    end
  endtask

  task automatic push_dump();
    exp_q.delete();
    for (int a = 0; a < IMG_SIZE; a++) begin
      logic [31:0] av;
      av = a;
      exp_q.push_back({av[ADDR_W-1:0], exp_res[av[ADDR_W-1:0]]});
    end
  endtask

  // Monitor: every dump word presented by the DUT is matched against the next expected word.
  always @(negedge clk) begin
    if (!reset && dout_valid) begin
      seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dump_unexpected: got word at addr %0d, expected none", dout_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dump_addr", 32'(dout_addr), 32'(mon_e[21:8]));
        chk("dump_data", 32'(dout_data), 32'(mon_e[7:0]));
      end
    end
  end

  initial begin
    logic found;
    int base;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_gray_ready", 32'(gray_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_gray_data", 32'(gray_data), 32'd0);
    reset = 1'b0;
    tick();

    // Run 1: load, reads, writes, dump to completion
    clear_model();
    load_image();
    rd(14'd129, 8'h81);   tick();
    rd(14'd0, 8'h00);     tick();
    rd(14'd16383, 8'hFF); tick();
    rd(14'd300, 8'h2C);   gray_req = 1'b0; #1;
    chk("gray_data_no_req", 32'(gray_data), 32'd0);
    tick();

    wr(14'd129, 8'h5A);   exp_res[14'd129] = 8'h5A;
    chk("wr_count_after_first", 32'(wr_count), 32'd1);
    lbp_valid = 1'b1; lbp_addr = 14'd16254; lbp_data = 8'h3C;
    tick(); tick(); tick();
    lbp_valid = 1'b0;     exp_res[14'd16254] = 8'h3C;
    chk("wr_count_held_strobe", 32'(wr_count), 32'd2);
    chk("err_held_strobe", 32'(err), 32'd0);
    wr(14'd200, 8'h77);   exp_res[14'd200] = 8'h77;
    chk("wr_count_third", 32'(wr_count), 32'd3);
    tick();
    wr(14'd129, 8'h22);
    chk("err_duplicate", 32'(err), 32'd1);
    chk("wr_count_duplicate", 32'(wr_count), 32'd3);

    push_dump();
    base = seen;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20000 && !found; n++) begin
      @(negedge clk);
      if (dout_valid && dout_addr == 14'd16383) found = 1'b1;
    end
    chk("last_dump_word_seen", 32'(found), 32'd1);
    if (found) begin
      chk("done_during_last_word", 32'(done), 32'd0);
      @(negedge clk);
      chk("done_after_last_word", 32'(done), 32'd1);
      chk("dout_valid_after_dump", 32'(dout_valid), 32'd0);
      chk("dump_word_count", 32'(seen - base), 32'(IMG_SIZE));
      chk("dump_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Run 2: border writes, then reset in the middle of the dump
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_done", 32'(done), 32'd0);
    chk("rst2_wr_count", 32'(wr_count), 32'd0);
    clear_model();
    load_image();
    wr(14'd0, 8'h01);
    chk("err_border_0", 32'(err), 32'd1);
    chk("wr_count_border_0", 32'(wr_count), 32'd0);
    wr(14'd127, 8'h02);
    chk("wr_count_border_127", 32'(wr_count), 32'd0);
    wr(14'd16256, 8'h03);
    chk("wr_count_border_16256", 32'(wr_count), 32'd0);
    wr(14'd1000, 8'hAB);  exp_res[14'd1000] = 8'hAB;
    chk("wr_count_interior", 32'(wr_count), 32'd1);

    push_dump();
    base = seen;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (seen - base >= 10) found = 1'b1;
    end
    chk("partial_dump_seen", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_dump_rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("mid_dump_rst_gray_ready", 32'(gray_ready), 32'd0);
    chk("mid_dump_rst_wr_count", 32'(wr_count), 32'd0);
    chk("mid_dump_rst_err", 32'(err), 32'd0);
    exp_q.delete();

    // Run 3: read request while loading is a protocol error
    reset = 1'b0;
    tick();
    rd(14'd129, 8'h00);
    tick();
    gray_req = 1'b0;
    chk("err_gray_req_in_load", 32'(err), 32'd1);
    chk("gray_ready_still_load", 32'(gray_ready), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
